tqvp_jnms_pdm_tx: RTL and testbench

TinyQV peripheral that converts 16-bit signed PCM samples written by the CPU into a 1-bit PDM stream with a matching PDM clock, for driving a PDM speaker amplifier or a filtered DAC pin. Samples are queued in a small FIFO and consumed at a programmable oversampling ratio. The block is the transmit counterpart of the team's PDM microphone peripheral. It uses the same register-bus conventions and the same clock-divider semantics, so one `PERIOD` value serves both directions.

---
 rtl/tqvp_jnms_pdm_tx_pkg.sv | 27 ++
 rtl/tqvp_jnms_pdm_tx_sigma_delta.sv | 55 +++++
 rtl/tqvp_jnms_pdm_tx.sv | 111 +++++++++++
 tb/tb_tqvp_jnms_pdm_tx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tqvp_jnms_pdm_tx_pkg.sv
// tqvp_jnms_pdm_tx_pkg: register map, STATUS layout, datapath widths and integrator saturation for the PDM transmitter.
package tqvp_jnms_pdm_tx_pkg;
  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_PERIOD = 6'h04;
  localparam logic [5:0] ADDR_OSR    = 6'h08;
  localparam logic [5:0] ADDR_DATA   = 6'h0C;
  localparam logic [5:0] ADDR_STATUS = 6'h10;
  localparam int ST_EMPTY    = 8;
  localparam int ST_FULL     = 9;
  localparam int ST_UNDERRUN = 16;
  localparam int ST_OVERFLOW = 17;
  localparam int SAMPLE_W = 16;
  localparam int INT_W    = 20;
  localparam int ACC_W    = INT_W + 2;
  localparam int LEVEL_W  = 5;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (INT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI;
  localparam logic signed [ACC_W-1:0] FB_MAG = ACC_W'(32768);

  function automatic logic signed [INT_W-1:0] sat_int(input logic signed [ACC_W-1:0] v);
    return (v > SAT_HI) ? SAT_HI[INT_W-1:0] : (v < SAT_LO) ? SAT_LO[INT_W-1:0] : v[INT_W-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] widen(input logic signed [INT_W-1:0] v);
    return {{(ACC_W - INT_W){v[INT_W-1]}}, v};
  endfunction
endpackage

// File: rtl/tqvp_jnms_pdm_tx_sigma_delta.sv
// pdm_sigma_delta: PCM-to-PDM modulator, first order by default, second order when PDM_TX_ORDER2_EN is defined.
module pdm_sigma_delta
  import tqvp_jnms_pdm_tx_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                step,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                pdm_dat
);
  logic dat_q, dat_d;
`ifdef PDM_TX_ORDER2_EN
  logic signed [INT_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic signed [ACC_W-1:0] fb, s1n, s2n;
  always_comb begin
    fb = dat_q ? FB_MAG : -FB_MAG;
    s1n = widen(s1_q) + ACC_W'($signed(sample)) - fb;
    s2n = widen(s2_q) + widen(sat_int(s1n)) - fb;
    s1_d = clr ? '0 : step ? sat_int(s1n) : s1_q;
    s2_d = clr ? '0 : step ? sat_int(s2n) : s2_q;
    dat_d = clr ? 1'b0 : step ? !s2n[ACC_W-1] : dat_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      dat_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      dat_q <= dat_d;
    end
  end
`else
  logic [SAMPLE_W-1:0] acc_q, acc_d;
  logic [SAMPLE_W:0] sum;
  // offset-binary input makes the carry-out density exactly u/65536
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, sample ^ 16'h8000};
    acc_d = clr ? '0 : step ? sum[SAMPLE_W-1:0] : acc_q;
    dat_d = clr ? 1'b0 : step ? sum[SAMPLE_W] : dat_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      dat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      dat_q <= dat_d;
    end
  end
`endif
  assign pdm_dat = dat_q;
endmodule

// File: rtl/tqvp_jnms_pdm_tx.sv
// tqvp_jnms_pdm_tx: TinyQV PCM-to-PDM transmitter with sample FIFO, clock divider and OSR bit counter.
// Build option PDM_TX_ORDER2_EN selects the second-order modulator in pdm_sigma_delta.
module tqvp_jnms_pdm_tx
  import tqvp_jnms_pdm_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [LEVEL_W-1:0] DEPTH_L = LEVEL_W'(FIFO_DEPTH);
  localparam logic [LEVEL_W-1:0] HALF_L = LEVEL_W'(FIFO_DEPTH / 2);
  logic enable_q, enable_d, pdm_clk_q, pdm_clk_d, underrun_q, underrun_d, overflow_q, overflow_d;
  logic [7:0] period_q, period_d, osr_q, osr_d, phase_q, phase_d, bitcnt_q, bitcnt_d, bit_nx;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic wr, run, step, pop_try, pop, push, push_ok, clr_st, pdm_dat;
  logic [31:0] status_rd;
  logic unused_ok;
  always_comb begin
    wr = data_write_n != 2'b11;
    run = enable_q && period_q > 8'd1;
    step = run && phase_q >= period_q - 8'd1;
    pop_try = step && bitcnt_q == 8'd0;
    pop = pop_try && level_q != '0;
    push = wr && address == ADDR_DATA;
    push_ok = push && (pop || level_q != DEPTH_L);
    clr_st = wr && address == ADDR_STATUS;
    enable_d = wr && address == ADDR_CTRL ? data_in[0] : enable_q;
    period_d = wr && address == ADDR_PERIOD ? data_in[7:0] : period_q;
    osr_d = wr && address == ADDR_OSR ? data_in[7:0] : osr_q;
    phase_d = run && !step ? phase_q + 8'd1 : 8'd0;
    pdm_clk_d = run && phase_d < (period_q >> 1);
    bit_nx = bitcnt_q + 8'd1;
    bitcnt_d = !enable_q ? 8'd0 : step ? (bit_nx == osr_q ? 8'd0 : bit_nx) : bitcnt_q;
    sample_d = pop ? mem_q[rd_ptr_q] : sample_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    level_d = level_q + LEVEL_W'(push_ok) - LEVEL_W'(pop);
    underrun_d = (underrun_q && !(clr_st && data_in[ST_UNDERRUN])) || (pop_try && level_q == '0);
    overflow_d = (overflow_q && !(clr_st && data_in[ST_OVERFLOW])) || (push && !push_ok);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable_q <= 1'b0;
      period_q <= '0;
      osr_q <= '0;
      phase_q <= '0;
      pdm_clk_q <= 1'b0;
      bitcnt_q <= '0;
      sample_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      enable_q <= enable_d;
      period_q <= period_d;
      osr_q <= osr_d;
      phase_q <= phase_d;
      pdm_clk_q <= pdm_clk_d;
      bitcnt_q <= bitcnt_d;
      sample_q <= sample_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q <= level_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) if (push_ok) mem_q[wr_ptr_q] <= data_in[SAMPLE_W-1:0];
  // the modulator sees the freshly popped sample on the step that pops it
  pdm_sigma_delta u_mod (
    .clk(clk),
    .rst_n(rst_n),
    .clr(!enable_q),
    .step(step),
    .sample(sample_d),
    .pdm_dat(pdm_dat)
  );
  always_comb begin
    status_rd = '0;
    status_rd[LEVEL_W-1:0] = level_q;
    status_rd[ST_EMPTY] = level_q == '0;
    status_rd[ST_FULL] = level_q == DEPTH_L;
    status_rd[ST_UNDERRUN] = underrun_q;
    status_rd[ST_OVERFLOW] = overflow_q;
  end
  assign data_out = address == ADDR_CTRL ? {31'b0, enable_q} :
                    address == ADDR_PERIOD ? {24'b0, period_q} :
                    address == ADDR_OSR ? {24'b0, osr_q} :
                    address == ADDR_DATA ? {{(32 - SAMPLE_W){sample_q[SAMPLE_W-1]}}, sample_q} :
                    address == ADDR_STATUS ? status_rd : 32'b0;
  assign uo_out = {5'b0, pdm_dat & enable_q, pdm_clk_q & enable_q, 1'b0};
  assign data_ready = 1'b1;
  assign user_interrupt = enable_q && level_q <= HALF_L;
  assign unused_ok = &{1'b0, ui_in, data_read_n, data_in[31:18]};
endmodule

// File: tb/tb_tqvp_jnms_pdm_tx.sv
// tb_tqvp_jnms_pdm_tx: directed plus randomized bench for the PDM transmitter against a queue-based behavioural model.
module tb_tqvp_jnms_pdm_tx;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  logic [5:0] address = 6'h00;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic [1:0] data_write_n = 2'b11, data_read_n = 2'b11;
  logic data_ready, user_interrupt;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  tqvp_jnms_pdm_tx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ui_in(ui_in),
    .uo_out(uo_out),
    .address(address),
    .data_in(data_in),
    .data_write_n(data_write_n),
    .data_read_n(data_read_n),
    .data_out(data_out),
    .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: samples in a queue, divider and bit counter as plain integers
  int m_en = 0, m_per = 0, m_osr = 0, m_sample = 0, m_und = 0, m_ovf = 0;
  int m_phase = 0, m_bit = 0, m_acc = 0, m_clk = 0, m_dat = 0, m_s1 = 0, m_s2 = 0;
  int q[$];

  function automatic int sat19(input int v);
    return v > 524287 ? 524287 : v < -524287 ? -524287 : v;
  endfunction

  always @(posedge clk) begin : mdl
    bit w, run, step;
    int nb;
`ifdef PDM_TX_ORDER2_EN
    int fb, sv, s2n;
`else
    int sum;
`endif
    if (!rst_n) begin
      m_en = 0; m_per = 0; m_osr = 0; m_sample = 0; m_und = 0; m_ovf = 0;
      m_phase = 0; m_bit = 0; m_acc = 0; m_clk = 0; m_dat = 0; m_s1 = 0; m_s2 = 0;
      q.delete();
    end else begin
      w = data_write_n != 2'b11;
      run = m_en != 0 && m_per >= 2;
      step = run && m_phase >= m_per - 1;
      if (w && address == 6'h10) begin
        if (data_in[16]) m_und = 0;
        if (data_in[17]) m_ovf = 0;
      end
      if (step) begin
        if (m_bit == 0) begin
          if (q.size() > 0) m_sample = q.pop_front();
          else m_und = 1;
        end
        nb = (m_bit + 1) % 256;
        m_bit = nb == m_osr ? 0 : nb;
`ifdef PDM_TX_ORDER2_EN
        fb = m_dat != 0 ? 32768 : -32768;
        sv = m_sample >= 32768 ? m_sample - 65536 : m_sample;
        m_s1 = sat19(m_s1 + sv - fb);
        s2n = m_s2 + m_s1 - fb;
        m_s2 = sat19(s2n);
        m_dat = s2n >= 0 ? 1 : 0;
`else
        sum = m_acc + (m_sample + 32768) % 65536;
        m_dat = sum / 65536;
        m_acc = sum % 65536;
`endif
      end
      m_phase = (!run || step) ? 0 : (m_phase + 1) % 256;
      m_clk = (run && m_phase < m_per / 2) ? 1 : 0;
      if (m_en == 0) begin
        m_bit = 0; m_acc = 0; m_dat = 0; m_s1 = 0; m_s2 = 0;
      end
      if (w && address == 6'h0C) begin
        if (q.size() < DEPTH) q.push_back(int'(data_in[15:0]));
        else m_ovf = 1;
      end
      if (w && address == 6'h00) m_en = int'(data_in[0]);
      if (w && address == 6'h04) m_per = int'(data_in[7:0]);
      if (w && address == 6'h08) m_osr = int'(data_in[7:0]);
    end
  end

  function automatic logic [31:0] m_read(input logic [5:0] a);
    case (a)
      6'h00: return 32'(m_en);
      6'h04: return 32'(m_per);
      6'h08: return 32'(m_osr);
      6'h0C: return m_sample >= 32768 ? 32'(m_sample - 65536) : 32'(m_sample);
      6'h10: return 32'(q.size()) | (q.size() == 0 ? 32'h100 : 32'h0) | (q.size() == DEPTH ? 32'h200 : 32'h0)
                    | (m_und != 0 ? 32'h10000 : 32'h0) | (m_ovf != 0 ? 32'h20000 : 32'h0);
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    chk("uo_out", {24'h0, uo_out}, 32'((m_en != 0 && m_dat != 0 ? 4 : 0) + (m_en != 0 && m_clk != 0 ? 2 : 0)));
    chk("irq", {31'h0, user_interrupt}, (m_en != 0 && q.size() <= DEPTH / 2) ? 32'h1 : 32'h0);
    chk("data_out", data_out, m_read(address));
    chk("data_ready", {31'h0, data_ready}, 32'h1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    address = a;
    data_in = d;
    data_write_n = 2'($urandom_range(0, 2));
    tick(1);
    data_write_n = 2'b11;
  endtask

  task automatic rd_chk(input string nm, input logic [5:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(nm, data_out, exp);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ones;
    logic [31:0] d;
    tick(2);
    rst_n = 1'b1;
    rd_chk("rst_ctrl", 6'h00, 32'h0);
    rd_chk("rst_period", 6'h04, 32'h0);
    rd_chk("rst_osr", 6'h08, 32'h0);
    rd_chk("rst_data", 6'h0C, 32'h0);
    rd_chk("rst_status", 6'h10, 32'h100);
    chk("rst_uo", {24'h0, uo_out}, 32'h0);
    chk("rst_irq", {31'h0, user_interrupt}, 32'h0);
    // zero sample, period 4, osr 4
    wr(6'h04, 4);
    wr(6'h08, 4);
    wr(6'h0C, 0);
    wr(6'h00, 1);
    tick(4);
    chk("bit0", {31'h0, uo_out[2]}, 32'h0);
    chk("clk_ph0", {31'h0, uo_out[1]}, 32'h1);
    tick(1);
    chk("clk_ph1", {31'h0, uo_out[1]}, 32'h1);
    tick(1);
    chk("clk_ph2", {31'h0, uo_out[1]}, 32'h0);
    tick(1);
    chk("clk_ph3", {31'h0, uo_out[1]}, 32'h0);
    tick(1);
    chk("bit1", {31'h0, uo_out[2]}, 32'h1);
    rd_chk("status_empty", 6'h10, 32'h100);
    tick(4);
    chk("bit2", {31'h0, uo_out[2]}, 32'h0);
    tick(4);
    chk("bit3", {31'h0, uo_out[2]}, 32'h1);
    rd_chk("status_no_underrun", 6'h10, 32'h100);
    tick(4);
    rd_chk("status_underrun", 6'h10, 32'h10100);
    wr(6'h00, 0);
    wr(6'h10, 32'h30000);
    rd_chk("status_cleared", 6'h10, 32'h100);
    // overflow with prefill while disabled
    for (int i = 0; i < 5; i++) wr(6'h0C, 32'(16'h1000 + i));
    rd_chk("status_overflow", 6'h10, 32'h20204);
    wr(6'h10, 32'h20000);
    rd_chk("status_ovf_clr", 6'h10, 32'h204);
    // interrupt level tracking, one pop per step
    wr(6'h08, 1);
    wr(6'h00, 1);
    chk("irq_lvl4", {31'h0, user_interrupt}, 32'h0);
    tick(4);
    chk("irq_lvl3", {31'h0, user_interrupt}, 32'h0);
    tick(4);
    chk("irq_lvl2", {31'h0, user_interrupt}, 32'h1);
    wr(6'h0C, 32'h55);
    chk("irq_push", {31'h0, user_interrupt}, 32'h0);
    wr(6'h00, 0);
    chk("irq_dis", {31'h0, user_interrupt}, 32'h0);
    rd_chk("data_head", 6'h0C, 32'h1001);
    // drain
    wr(6'h04, 2);
    wr(6'h00, 1);
    tick(8);
    wr(6'h00, 0);
    wr(6'h10, 32'h30000);
    rd_chk("drained", 6'h10, 32'h100);
    // full-scale positive, OSR 256
    wr(6'h0C, 32'h7FFF);
    wr(6'h08, 0);
    wr(6'h00, 1);
    ones = 0;
    repeat (256) begin
      tick(2);
      ones += int'(uo_out[2]);
    end
    chk("ones_7fff", 32'(ones), 32'd255);
    rd_chk("one_pop", 6'h10, 32'h100);
    rd_chk("data_7fff", 6'h0C, 32'h7FFF);
    wr(6'h00, 0);
    // -16384 for 1024 bits: density one quarter
    for (int i = 0; i < 4; i++) wr(6'h0C, 32'hC000);
    wr(6'h00, 1);
    ones = 0;
    repeat (1024) begin
      tick(2);
      ones += int'(uo_out[2]);
    end
    n_chk++;
    if (ones < 254 || ones > 258) begin
      n_err++;
      $display("FAIL ones_c000: got %0d expected 256+-2", ones);
    end
    wr(6'h00, 0);
    rd_chk("data_sext", 6'h0C, 32'hFFFFC000);
    rd_chk("no_underrun", 6'h10, 32'h100);
    // reset mid-stream flushes everything
    wr(6'h0C, 1);
    wr(6'h0C, 2);
    wr(6'h00, 1);
    tick(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    rd_chk("mid_rst_status", 6'h10, 32'h100);
    rd_chk("mid_rst_ctrl", 6'h00, 32'h0);
    rd_chk("mid_rst_per", 6'h04, 32'h0);
    chk("mid_rst_uo", {24'h0, uo_out}, 32'h0);
    // randomized traffic, checked every cycle by the model
    repeat (3000) begin
      int op;
      op = $urandom_range(0, 99);
      d = $urandom;
      if (op < 30) wr(6'h0C, d);
      else if (op < 36) begin
        d[0] = $urandom_range(0, 9) < 7;
        wr(6'h00, d);
      end else if (op < 40) begin
        d[7:0] = 8'($urandom_range(0, 9));
        wr(6'h04, d);
      end else if (op < 44) begin
        d[7:0] = 8'($urandom_range(0, 6));
        wr(6'h08, d);
      end else if (op < 48) wr(6'h10, d);
      else if (op < 49) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end else if (op < 52) wr(6'($urandom_range(20, 63)), d);
      else begin
        address = (op < 80) ? 6'(4 * $urandom_range(0, 4)) : 6'($urandom_range(0, 63));
        tick(1);
      end
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
